// File: rtl/dma_pcie_cfg_mgmt_pkg.sv
// Shared types and constants for the PCIe cfg_mgmt master.
// Holds the FSM encoding and the cfg_mgmt field widths.
package dma_pcie_cfg_mgmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CFG_MGMT_ADDR_W = 10;
  localparam int FUNC_W          = 8;
  localparam int DATA_W          = 32;
  localparam int BE_W            = 4;

  localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dma_pcie_cfg_mgmt_master.sv
// Serialises dword config-space requests onto the PCIe core cfg_mgmt port.
// Holds the strobe until done, with a timeout so a hung core cannot stall the register path.
module dma_pcie_cfg_mgmt_master
  import dma_pcie_cfg_mgmt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                       user_clk,
  input  logic                       user_reset,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic                       req_wr,
  input  logic [CFG_MGMT_ADDR_W-1:0] req_addr,
  input  logic [FUNC_W-1:0]          req_func,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [BE_W-1:0]            req_be,
  output logic                       rsp_vld,
  input  logic                       rsp_rdy,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [CFG_MGMT_ADDR_W-1:0] cfg_mgmt_addr,
  output logic [FUNC_W-1:0]          cfg_mgmt_function_number,
  output logic                       cfg_mgmt_write,
  output logic [DATA_W-1:0]          cfg_mgmt_write_data,
  output logic [BE_W-1:0]            cfg_mgmt_byte_enable,
  output logic                       cfg_mgmt_read,
  input  logic [DATA_W-1:0]          cfg_mgmt_read_data,
  input  logic                       cfg_mgmt_read_write_done,
  output logic                       busy,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e                       state_q, state_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [CFG_MGMT_ADDR_W-1:0]   addr_d;
  logic [FUNC_W-1:0]            func_d;
  logic [DATA_W-1:0]            wdata_d;
  logic [BE_W-1:0]              be_d;
  logic                         wr_d, rd_d;
  logic                         rsp_vld_d, rsp_err_d;
  logic [DATA_W-1:0]            rsp_rdata_d;
  logic [ERR_CNT_W-1:0]         err_cnt_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    timer_d     = timer_q;
    addr_d      = cfg_mgmt_addr;
    func_d      = cfg_mgmt_function_number;
    wdata_d     = cfg_mgmt_write_data;
    be_d        = cfg_mgmt_byte_enable;
    wr_d        = cfg_mgmt_write;
    rd_d        = cfg_mgmt_read;
    rsp_vld_d   = rsp_vld;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    err_cnt_d   = err_cnt;

    unique case (state_q)
      IDLE: begin
        if (req_vld) begin
          addr_d  = req_addr;
          func_d  = req_func;
          wdata_d = req_wdata;
          // Reads carry no byte enables on cfg_mgmt.
          be_d    = req_wr ? req_be : '0;
          wr_d    = req_wr;
          rd_d    = !req_wr;
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // done is checked first so a completion landing on the last timer cycle is not an error.
        if (cfg_mgmt_read_write_done) begin
          wr_d        = 1'b0;
          rd_d        = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = cfg_mgmt_read ? cfg_mgmt_read_data : '0;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timer_q == TMR_LAST) begin
          wr_d        = 1'b0;
          rd_d        = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = RD_TIMEOUT_DATA;
          rsp_err_d   = 1'b1;
          if (err_cnt != '1) err_cnt_d = err_cnt + 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q                  <= IDLE;
      timer_q                  <= '0;
      req_rdy                  <= 1'b1;
      busy                     <= 1'b0;
      cfg_mgmt_addr            <= '0;
      cfg_mgmt_function_number <= '0;
      cfg_mgmt_write_data      <= '0;
      cfg_mgmt_byte_enable     <= '0;
      cfg_mgmt_write           <= 1'b0;
      cfg_mgmt_read            <= 1'b0;
      rsp_vld                  <= 1'b0;
      rsp_rdata                <= '0;
      rsp_err                  <= 1'b0;
      err_cnt                  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
      state_q                  <= state_d;
      timer_q                  <= timer_d;
      req_rdy                  <= (state_d == IDLE);
      busy                     <= (state_d != IDLE);
      cfg_mgmt_addr            <= addr_d;
      cfg_mgmt_function_number <= func_d;
      cfg_mgmt_write_data      <= wdata_d;
      cfg_mgmt_byte_enable     <= be_d;
      cfg_mgmt_write           <= wr_d;
      cfg_mgmt_read            <= rd_d;
      rsp_vld                  <= rsp_vld_d;
      rsp_rdata                <= rsp_rdata_d;
      rsp_err                  <= rsp_err_d;
      err_cnt                  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_pcie_cfg_mgmt_master.sv
// Directed bench for dma_pcie_cfg_mgmt_master: reads, writes, timeouts, back-pressure,
// mid-transaction reset and error-counter saturation, all with hand-computed expectations.
module tb_dma_pcie_cfg_mgmt_master;

  localparam int TIMEOUT = 16;
  localparam int ERR_W   = 2;

  logic              user_clk = 1'b0;
  logic              user_reset;
  logic              req_vld, req_rdy, req_wr;
  logic [9:0]        req_addr;
  logic [7:0]        req_func;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_vld, rsp_rdy, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [9:0]        cfg_mgmt_addr;
  logic [7:0]        cfg_mgmt_function_number;
  logic              cfg_mgmt_write, cfg_mgmt_read;
  logic [31:0]       cfg_mgmt_write_data, cfg_mgmt_read_data;
  logic [3:0]        cfg_mgmt_byte_enable;
  logic              cfg_mgmt_read_write_done;
  logic              busy;
  logic [ERR_W-1:0]  err_cnt;

  always #5 user_clk = ~user_clk;

  dma_pcie_cfg_mgmt_master #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .ERR_CNT_W      (ERR_W)
  ) dut (
    .user_clk                 (user_clk),
    .user_reset               (user_reset),
    .req_vld                  (req_vld),
    .req_rdy                  (req_rdy),
    .req_wr                   (req_wr),
    .req_addr                 (req_addr),
    .req_func                 (req_func),
    .req_wdata                (req_wdata),
    .req_be                   (req_be),
    .rsp_vld                  (rsp_vld),
    .rsp_rdy                  (rsp_rdy),
    .rsp_rdata                (rsp_rdata),
    .rsp_err                  (rsp_err),
    .cfg_mgmt_addr            (cfg_mgmt_addr),
    .cfg_mgmt_function_number (cfg_mgmt_function_number),
    .cfg_mgmt_write           (cfg_mgmt_write),
    .cfg_mgmt_write_data      (cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
    .cfg_mgmt_read            (cfg_mgmt_read),
    .cfg_mgmt_read_data       (cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done),
    .busy                     (busy),
    .err_cnt                  (err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_total = 0;
  int both_total   = 0;
  int hs_total     = 0;

  // Strobe-high cycles, illegal double strobes and response handshakes, sampled mid-cycle.
  always @(negedge user_clk) begin
    if (cfg_mgmt_read || cfg_mgmt_write) strobe_total <= strobe_total + 1;
    if (cfg_mgmt_read && cfg_mgmt_write) both_total   <= both_total + 1;
    if (rsp_vld && rsp_rdy)              hs_total     <= hs_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [9:0] a, input logic [7:0] f,
                       input logic [31:0] d, input logic [3:0] be);
    req_wr = wr; req_addr = a; req_func = f; req_wdata = d; req_be = be;
    req_vld = 1'b1;
    for (int i = 0; i < 40 && !req_rdy; i++) step();
    check("req_rdy_at_issue", 32'(req_rdy), 32'd1);
    step();
    req_vld = 1'b0;
  endtask

  // Called in the first strobe-high cycle; done is driven in the k-th strobe cycle.
  task automatic finish_done(input int k, input logic [31:0] data);
    if (k > 1) step(k - 1);
    cfg_mgmt_read_write_done = 1'b1;
    cfg_mgmt_read_data       = data;
    step();
    cfg_mgmt_read_write_done = 1'b0;
    cfg_mgmt_read_data       = 32'h0BAD_0BAD;
  endtask

  task automatic handshake();
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    check("hs_rsp_vld", 32'(rsp_vld), 32'd0);
    check("hs_req_rdy", 32'(req_rdy), 32'd1);
    check("hs_busy",    32'(busy),    32'd0);
  endtask

  task automatic run_timeout(input int exp_cnt, input bit late_done);
    int s0;
    s0 = strobe_total;
    issue(1'b0, 10'h010, 8'h00, 32'h0, 4'h0);
    for (int i = 0; i < 40 && !rsp_vld; i++) step();
    check("to_rsp_vld",     32'(rsp_vld), 32'd1);
    check("to_strobe_cyc",  32'(strobe_total - s0), 32'(TIMEOUT));
    check("to_rsp_err",     32'(rsp_err), 32'd1);
    check("to_rsp_rdata",   rsp_rdata, 32'hFFFF_FFFF);
    check("to_err_cnt",     32'(err_cnt), 32'(exp_cnt));
    if (late_done) begin
      cfg_mgmt_read_write_done = 1'b1;
      cfg_mgmt_read_data       = 32'h1234_0000;
      step();
      cfg_mgmt_read_write_done = 1'b0;
      check("late_done_rsp_vld",   32'(rsp_vld), 32'd1);
      check("late_done_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
      check("late_done_rsp_err",   32'(rsp_err), 32'd1);
    end
    handshake();
    if (late_done) begin
      cfg_mgmt_read_write_done = 1'b1;
      step();
      cfg_mgmt_read_write_done = 1'b0;
      check("idle_done_busy",    32'(busy),          32'd0);
      check("idle_done_rsp_vld", 32'(rsp_vld),       32'd0);
      check("idle_done_strobe",  32'(cfg_mgmt_read), 32'd0);
    end
  endtask

  initial begin
    int s0, h0;
    logic [31:0] held;

    user_reset = 1'b1;
    req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_func = '0; req_wdata = '0; req_be = '0;
    rsp_rdy = 1'b0;
    cfg_mgmt_read_data = 32'h0BAD_0BAD;
    cfg_mgmt_read_write_done = 1'b0;
    step(3);
    user_reset = 1'b0;

    check("rst_req_rdy", 32'(req_rdy),        32'd1);
    check("rst_busy",    32'(busy),           32'd0);
    check("rst_rsp_vld", 32'(rsp_vld),        32'd0);
    check("rst_strobes", 32'({cfg_mgmt_read, cfg_mgmt_write}), 32'd0);
    check("rst_err_cnt", 32'(err_cnt),        32'd0);

    // Read func 0 addr 0x004, done in the 5th strobe cycle.
    s0 = strobe_total; h0 = hs_total;
    issue(1'b0, 10'h004, 8'h00, 32'hDEAD_BEEF, 4'hF);
    check("rd_strobe",  32'(cfg_mgmt_read),  32'd1);
    check("rd_no_wr",   32'(cfg_mgmt_write), 32'd0);
    check("rd_addr",    32'(cfg_mgmt_addr),  32'h004);
    check("rd_func",    32'(cfg_mgmt_function_number), 32'h00);
    check("rd_be_zero", 32'(cfg_mgmt_byte_enable), 32'h0);
    check("rd_req_rdy", 32'(req_rdy), 32'd0);
    check("rd_busy",    32'(busy),    32'd1);
    finish_done(5, 32'h0010_0007);
    check("rd_strobe_cyc", 32'(strobe_total - s0), 32'd5);
    check("rd_strobe_low", 32'(cfg_mgmt_read), 32'd0);
    check("rd_rsp_vld",    32'(rsp_vld), 32'd1);
    check("rd_rsp_rdata",  rsp_rdata, 32'h0010_0007);
    check("rd_rsp_err",    32'(rsp_err), 32'd0);
    handshake();
    check("rd_one_rsp", 32'(hs_total - h0), 32'd1);

    // Write func 3 addr 0x001 data 6 be 1; read data on done must be ignored.
    s0 = strobe_total;
    issue(1'b1, 10'h001, 8'h03, 32'h0000_0006, 4'h1);
    check("wr_strobe", 32'(cfg_mgmt_write), 32'd1);
    check("wr_no_rd",  32'(cfg_mgmt_read),  32'd0);
    check("wr_addr",   32'(cfg_mgmt_addr),  32'h001);
    check("wr_func",   32'(cfg_mgmt_function_number), 32'h03);
    check("wr_data",   cfg_mgmt_write_data, 32'h0000_0006);
    check("wr_be",     32'(cfg_mgmt_byte_enable), 32'h1);
    finish_done(5, 32'hAAAA_5555);
    check("wr_strobe_cyc", 32'(strobe_total - s0), 32'd5);
    check("wr_rsp_vld",    32'(rsp_vld), 32'd1);
    check("wr_rsp_rdata",  rsp_rdata, 32'h0);
    check("wr_rsp_err",    32'(rsp_err), 32'd0);
    handshake();

    // Timeout with late done in RESP and in IDLE.
    run_timeout(1, 1'b1);

    // Back-pressure: response held 10 cycles while a new request waits.
    issue(1'b0, 10'h020, 8'h01, 32'h0, 4'h0);
    finish_done(2, 32'h1234_5678);
    held = rsp_rdata;
    check("bp_rsp_rdata", held, 32'h1234_5678);
    req_wr = 1'b1; req_addr = 10'h02A; req_func = 8'h02; req_wdata = 32'h0000_55AA; req_be = 4'hC;
    req_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_vld",   32'(rsp_vld), 32'd1);
      check("bp_hold_rdata", rsp_rdata, held);
      check("bp_req_rdy",    32'(req_rdy), 32'd0);
      check("bp_no_strobe",  32'({cfg_mgmt_read, cfg_mgmt_write}), 32'd0);
    end
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    check("bp_hs_vld",     32'(rsp_vld), 32'd0);
    check("bp_hs_req_rdy", 32'(req_rdy), 32'd1);
    check("bp_hs_no_wr",   32'(cfg_mgmt_write), 32'd0);
    step();
    req_vld = 1'b0;
    check("bp_next_wr",   32'(cfg_mgmt_write), 32'd1);
    check("bp_next_addr", 32'(cfg_mgmt_addr), 32'h02A);
    check("bp_next_data", cfg_mgmt_write_data, 32'h0000_55AA);
    check("bp_next_be",   32'(cfg_mgmt_byte_enable), 32'hC);
    finish_done(1, 32'h0);
    check("bp_next_rsp", 32'(rsp_vld), 32'd1);
    handshake();

    // Reset while waiting on the core.
    h0 = hs_total;
    issue(1'b1, 10'h003, 8'h00, 32'h1, 4'hF);
    step(2);
    user_reset = 1'b1;
    step();
    check("mrst_strobes", 32'({cfg_mgmt_read, cfg_mgmt_write}), 32'd0);
    check("mrst_req_rdy", 32'(req_rdy), 32'd1);
    check("mrst_busy",    32'(busy),    32'd0);
    check("mrst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt), 32'd0);
    user_reset = 1'b0;
    cfg_mgmt_read_write_done = 1'b1;
    step();
    cfg_mgmt_read_write_done = 1'b0;
    step();
    check("mrst_done_rsp_vld", 32'(rsp_vld), 32'd0);
    check("mrst_done_busy",    32'(busy),    32'd0);
    check("mrst_no_rsp",       32'(hs_total - h0), 32'd0);

    // Done on the same cycle the timer expires: done wins.
    s0 = strobe_total;
    issue(1'b0, 10'h040, 8'h00, 32'h0, 4'h0);
    finish_done(TIMEOUT, 32'hCAFE_0001);
    check("tie_strobe_cyc", 32'(strobe_total - s0), 32'(TIMEOUT));
    check("tie_rsp_vld",    32'(rsp_vld), 32'd1);
    check("tie_rsp_err",    32'(rsp_err), 32'd0);
    check("tie_rsp_rdata",  rsp_rdata, 32'hCAFE_0001);
    check("tie_err_cnt",    32'(err_cnt), 32'd0);
    handshake();

    // Error counter climbs to all-ones and stays there.
    run_timeout(1, 1'b0);
    run_timeout(2, 1'b0);
    run_timeout(3, 1'b0);
    run_timeout(3, 1'b0);

    step();
    check("never_both_strobes", 32'(both_total), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
